rr_operand_stage: RTL and testbench

- Register-read stage: sits directly downstream of the 8x16 register file and upstream of EX in the 6-stage pipeline.
- Drives register-file read addresses, resolves data hazards by forwarding from EX/MEM/WB, and detects load-use hazards to insert one-cycle bubbles.
- Holds the RR/EX pipeline register (valid, operands, control) with stall and flush support, and counts interlock stall cycles.

---
 rtl/rr_operand_stage.sv | 141 ++++++++++++++
 tb/tb_rr_operand_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_operand_stage.sv
// rr_operand_stage
//   Register-read stage between the 8x16 register file and EX.
//   - Drives register-file read addresses straight from decode.
//   - Resolves RAW hazards by forwarding from EX, MEM and WB (in that order).
//   - Detects load-use hazards and inserts a single bubble while holding IF/ID.
//   - Holds the RR/EX pipeline register with stall/flush support.
//   - Counts load-use interlock cycles in a saturating counter.
//
// Ports
//   clk, rst                    clock and synchronous active-high reset
//   id_*                        decoded instruction fields from ID
//   rf_ra_addr/rf_rb_addr       register-file read addresses (combinational)
//   rf_ra/rf_rb                 register-file read data
//   ex_result                   ALU result of the instruction now in rr_*
//   mem_rd/mem_reg_write/mem_result   MEM-stage writeback info
//   wb_rd/wb_reg_write/wb_data        WB-stage register-file write
//   stall_in, flush             downstream hold request / branch kill
//   stall_out                   hold IF/ID this cycle
//   rr_*                        registered RR/EX pipeline outputs
//   stall_cnt                   saturating load-use stall count
module rr_operand_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [15:0]       id_pc,
  input  logic [2:0]        id_ra_addr,
  input  logic [2:0]        id_rb_addr,
  input  logic              id_uses_ra,
  input  logic              id_uses_rb,
  input  logic [2:0]        id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [15:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [2:0]        rf_ra_addr,
  output logic [2:0]        rf_rb_addr,
  input  logic [15:0]       rf_ra,
  input  logic [15:0]       rf_rb,
  input  logic [15:0]       ex_result,
  input  logic [2:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic [15:0]       mem_result,
  input  logic [2:0]        wb_rd,
  input  logic              wb_reg_write,
  input  logic [15:0]       wb_data,
  input  logic              stall_in,
  input  logic              flush,
  output logic              stall_out,
  output logic              rr_valid,
  output logic [15:0]       rr_pc,
  output logic [15:0]       rr_opa,
  output logic [15:0]       rr_opb,
  output logic [15:0]       rr_imm,
  output logic [2:0]        rr_rd,
  output logic              rr_reg_write,
  output logic              rr_mem_read,
  output logic [CTRL_W-1:0] rr_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic        ex_fwd_ok;
  logic [15:0] fwd_a;
  logic [15:0] fwd_b;
  logic        hazard;
  logic        count_en;

  assign rf_ra_addr = id_ra_addr;
  assign rf_rb_addr = id_rb_addr;

  // A load in EX has no data yet, so it must never be forwarded from EX;
  // that case is covered by the load-use bubble instead.
  assign ex_fwd_ok = rr_valid & rr_reg_write & ~rr_mem_read;

  // Forwarding muxes. WB is needed because the register file only updates
  // on the clock edge, so a same-cycle write is not yet visible on rf_*.
  always_comb begin
    fwd_a = rf_ra;
    if (ex_fwd_ok && rr_rd == id_ra_addr)
      fwd_a = ex_result;
    else if (mem_reg_write && mem_rd == id_ra_addr)
      fwd_a = mem_result;
    else if (wb_reg_write && wb_rd == id_ra_addr)
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = rf_rb;
    if (ex_fwd_ok && rr_rd == id_rb_addr)
      fwd_b = ex_result;
    else if (mem_reg_write && mem_rd == id_rb_addr)
      fwd_b = mem_result;
    else if (wb_reg_write && wb_rd == id_rb_addr)
      fwd_b = wb_data;
  end

  assign hazard = id_valid & rr_valid & rr_mem_read & rr_reg_write &
                  ((id_uses_ra & (rr_rd == id_ra_addr)) |
                   (id_uses_rb & (rr_rd == id_rb_addr)));

  // A flush discards the ID instruction anyway, so there is nothing to hold.
  assign stall_out = (stall_in | hazard) & ~flush;

  assign count_en = hazard & ~stall_in & ~flush;

  // RR/EX pipeline register: flush beats stall, stall beats hazard bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall_in && hazard)) begin
      rr_valid     <= 1'b0;
      rr_pc        <= '0;
      rr_opa       <= '0;
      rr_opb       <= '0;
      rr_imm       <= '0;
      rr_rd        <= '0;
      rr_reg_write <= 1'b0;
      rr_mem_read  <= 1'b0;
      rr_ctrl      <= '0;
    end else if (!stall_in) begin
      rr_valid     <= id_valid;
      rr_pc        <= id_pc;
      rr_opa       <= fwd_a;
      rr_opb       <= fwd_b;
      rr_imm       <= id_imm;
      rr_rd        <= id_rd;
      rr_reg_write <= id_valid & id_reg_write;
      rr_mem_read  <= id_valid & id_mem_read;
      rr_ctrl      <= id_ctrl;
    end
  end

  // Saturating interlock counter; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (count_en && stall_cnt != {CNT_W{1'b1}})
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_rr_operand_stage.sv
// tb_rr_operand_stage
//   Directed bench for rr_operand_stage. A forwarding table covers MEM/WB/RF
//   selection; hand sequences cover EX priority, load-use bubbles, hold,
//   flush and counter saturation (counter built 4 bits wide).
module tb_rr_operand_stage;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [15:0]       id_pc;
  logic [2:0]        id_ra_addr;
  logic [2:0]        id_rb_addr;
  logic              id_uses_ra;
  logic              id_uses_rb;
  logic [2:0]        id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [15:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [2:0]        rf_ra_addr;
  logic [2:0]        rf_rb_addr;
  logic [15:0]       rf_ra;
  logic [15:0]       rf_rb;
  logic [15:0]       ex_result;
  logic [2:0]        mem_rd;
  logic              mem_reg_write;
  logic [15:0]       mem_result;
  logic [2:0]        wb_rd;
  logic              wb_reg_write;
  logic [15:0]       wb_data;
  logic              stall_in;
  logic              flush;
  logic              stall_out;
  logic              rr_valid;
  logic [15:0]       rr_pc;
  logic [15:0]       rr_opa;
  logic [15:0]       rr_opb;
  logic [15:0]       rr_imm;
  logic [2:0]        rr_rd;
  logic              rr_reg_write;
  logic              rr_mem_read;
  logic [CTRL_W-1:0] rr_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int errorCount = 0;
  int checkCount = 0;
  int expCnt = 0;

  rr_operand_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .ex_result(ex_result),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
    .rr_valid(rr_valid), .rr_pc(rr_pc), .rr_opa(rr_opa), .rr_opb(rr_opb),
    .rr_imm(rr_imm), .rr_rd(rr_rd), .rr_reg_write(rr_reg_write),
    .rr_mem_read(rr_mem_read), .rr_ctrl(rr_ctrl), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  mrd;
    logic        mwe;
    logic [15:0] mres;
    logic [2:0]  wrd;
    logic        wwe;
    logic [15:0] wdat;
    logic [15:0] rfa;
    logic [15:0] rfb;
    logic [15:0] pc;
    logic [7:0]  ctrl;
    logic [15:0] expOpa;
    logic [15:0] expOpb;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Quiet bus: no instruction, no forwarding sources, no stall/flush.
  task automatic setIdle();
    id_valid = 0; id_pc = 0; id_ra_addr = 0; id_rb_addr = 0;
    id_uses_ra = 0; id_uses_rb = 0; id_rd = 0; id_reg_write = 0;
    id_mem_read = 0; id_imm = 0; id_ctrl = 0;
    rf_ra = 0; rf_rb = 0; ex_result = 16'hEEEE;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
    stall_in = 0; flush = 0;
  endtask

  task automatic issue(input logic [15:0] pc, input logic [2:0] ra, input logic [2:0] rb,
                       input logic ua, input logic ub, input logic [2:0] rd,
                       input logic rw, input logic mr);
    id_valid = 1; id_pc = pc; id_ra_addr = ra; id_rb_addr = rb;
    id_uses_ra = ua; id_uses_rb = ub; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic applyStimulus(input vec_t v);
    setIdle();
    issue(v.pc, v.ra, v.rb, 1, 1, 3'd1, 0, 0);
    id_imm = ~v.pc; id_ctrl = v.ctrl;
    mem_rd = v.mrd; mem_reg_write = v.mwe; mem_result = v.mres;
    wb_rd = v.wrd; wb_reg_write = v.wwe; wb_data = v.wdat;
    rf_ra = v.rfa; rf_rb = v.rfb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            ra   rb   mrd  mwe mres      wrd  wwe wdat      rfa       rfb       pc        ctrl   expA      expB
    vecs[0] = '{3'd1,3'd2,3'd0,1'b0,16'h0000,3'd0,1'b0,16'h0000,16'h1234,16'h00FF,16'h0010,8'h5C,16'h1234,16'h00FF};
    vecs[1] = '{3'd3,3'd4,3'd3,1'b1,16'hBBBB,3'd3,1'b1,16'hCCCC,16'h1111,16'h2222,16'h0012,8'h11,16'hBBBB,16'h2222};
    vecs[2] = '{3'd5,3'd6,3'd0,1'b1,16'h0DEF,3'd6,1'b1,16'h7777,16'h3333,16'h4444,16'h0014,8'h22,16'h3333,16'h7777};
    vecs[3] = '{3'd7,3'd7,3'd7,1'b0,16'hDEAD,3'd7,1'b1,16'hBEEF,16'h0101,16'h0202,16'h0016,8'h33,16'hBEEF,16'hBEEF};
    vecs[4] = '{3'd0,3'd0,3'd0,1'b1,16'h0A0A,3'd5,1'b0,16'h0000,16'h9090,16'h8080,16'h0018,8'h44,16'h0A0A,16'h0A0A};
    vecs[5] = '{3'd2,3'd3,3'd3,1'b1,16'h4444,3'd2,1'b0,16'h9999,16'h5555,16'h6666,16'h001A,8'h55,16'h5555,16'h4444};

    // Reset with garbage on the inputs and stall_in high.
    setIdle();
    issue(16'hFFFF, 3'd1, 3'd1, 1, 1, 3'd1, 1, 1);
    rf_ra = 16'hFFFF; stall_in = 1; rst = 1;
    tick();
    checkOutput("rst_valid", rr_valid, 0);
    checkOutput("rst_pc", rr_pc, 0);
    checkOutput("rst_opa", rr_opa, 0);
    checkOutput("rst_rw_mr", {rr_reg_write, rr_mem_read}, 0);
    checkOutput("rst_cnt", stall_cnt, 0);
    checkOutput("rst_stall_out_hi", stall_out, 1);
    rst = 0; setIdle(); #1;
    checkOutput("rst_stall_out_lo", stall_out, 0);
    checkOutput("rf_addr", {rf_ra_addr, rf_rb_addr}, 0);

    // Forwarding table (no writer ever sits in EX, so EX never matches).
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_rf_addr", i), {rf_ra_addr, rf_rb_addr}, {vecs[i].ra, vecs[i].rb});
      checkOutput($sformatf("v%0d_stall_out", i), stall_out, 0);
      tick();
      checkOutput($sformatf("v%0d_opa", i), rr_opa, vecs[i].expOpa);
      checkOutput($sformatf("v%0d_opb", i), rr_opb, vecs[i].expOpb);
      checkOutput($sformatf("v%0d_pc", i), rr_pc, vecs[i].pc);
      checkOutput($sformatf("v%0d_valid", i), rr_valid, 1);
      checkOutput($sformatf("v%0d_ctrl_imm", i), {rr_ctrl, rr_imm}, {vecs[i].ctrl, ~vecs[i].pc});
    end

    // EX > MEM > WB priority on source A = R3.
    setIdle(); issue(16'h0100, 3'd0, 3'd0, 0, 0, 3'd3, 1, 0);
    tick();
    checkOutput("ex_writer_rw", rr_reg_write, 1);
    setIdle(); issue(16'h0102, 3'd3, 3'd1, 1, 0, 3'd4, 0, 0);
    ex_result = 16'hAAAA; mem_rd = 3; mem_reg_write = 1; mem_result = 16'hBBBB;
    wb_rd = 3; wb_reg_write = 1; wb_data = 16'hCCCC; rf_ra = 16'h1111;
    tick();
    checkOutput("prio_ex", rr_opa, 16'hAAAA);
    tick();
    checkOutput("prio_mem", rr_opa, 16'hBBBB);
    mem_reg_write = 0;
    tick();
    checkOutput("prio_wb", rr_opa, 16'hCCCC);
    id_valid = 0;
    tick();
    checkOutput("idle_valid", rr_valid, 0);

    // Load-use: load R2 then use R2.
    setIdle(); issue(16'h0200, 3'd0, 3'd0, 0, 0, 3'd2, 1, 1);
    tick();
    checkOutput("ld_mem_read", rr_mem_read, 1);
    setIdle(); issue(16'h0202, 3'd2, 3'd0, 1, 0, 3'd5, 1, 0);
    ex_result = 16'h1111; rf_ra = 16'h2222; #1;
    checkOutput("lu_stall_out", stall_out, 1);
    tick();
    expCnt = 1;
    checkOutput("lu_bubble", rr_valid, 0);
    checkOutput("lu_cnt", stall_cnt, expCnt);
    mem_rd = 2; mem_reg_write = 1; mem_result = 16'h5A5A; #1;
    checkOutput("lu_release", stall_out, 0);
    tick();
    checkOutput("lu_opa", rr_opa, 16'h5A5A);
    checkOutput("lu_valid", rr_valid, 1);
    checkOutput("lu_cnt_hold", stall_cnt, expCnt);

    // Hold for 3 cycles, then flush beats stall_in.
    setIdle(); issue(16'h0ABC, 3'd1, 3'd2, 1, 1, 3'd6, 1, 0);
    rf_ra = 16'h4321; rf_rb = 16'h8765;
    tick();
    stall_in = 1; issue(16'h0DDD, 3'd3, 3'd4, 1, 1, 3'd7, 1, 0);
    rf_ra = 16'h0F0F; rf_rb = 16'hF0F0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("hold%0d_stall_out", i), stall_out, 1);
      tick();
      checkOutput($sformatf("hold%0d_pc", i), rr_pc, 16'h0ABC);
      checkOutput($sformatf("hold%0d_ops", i), {rr_opa, rr_opb}, {16'h4321, 16'h8765});
      checkOutput($sformatf("hold%0d_valid_rd", i), {rr_valid, rr_rd}, {1'b1, 3'd6});
    end
    flush = 1; #1;
    checkOutput("flush_stall_out", stall_out, 0);
    tick();
    checkOutput("flush_bubble", {rr_valid, rr_reg_write, rr_mem_read}, 0);

    // Hazard under stall_in holds without counting; hazard with flush neither.
    setIdle(); issue(16'h0300, 3'd0, 3'd0, 0, 0, 3'd5, 1, 1);
    tick();
    issue(16'h0302, 3'd0, 3'd5, 0, 1, 3'd1, 1, 0);
    stall_in = 1; #1;
    checkOutput("hz_stall_stall_out", stall_out, 1);
    tick();
    checkOutput("hz_stall_hold", {rr_valid, rr_mem_read, rr_pc}, {1'b1, 1'b1, 16'h0300});
    checkOutput("hz_stall_cnt", stall_cnt, expCnt);
    stall_in = 0; flush = 1; #1;
    checkOutput("hz_flush_stall_out", stall_out, 0);
    tick();
    checkOutput("hz_flush_valid", rr_valid, 0);
    checkOutput("hz_flush_cnt", stall_cnt, expCnt);

    // Unused source must not trigger a hazard.
    setIdle(); issue(16'h0400, 3'd0, 3'd0, 0, 0, 3'd4, 1, 1);
    tick();
    issue(16'h0402, 3'd4, 3'd4, 0, 0, 3'd1, 1, 0); #1;
    checkOutput("nouse_stall_out", stall_out, 0);
    tick();
    checkOutput("nouse_valid", rr_valid, 1);

    // 20 load-use pairs: counter climbs then sticks at 0xF.
    for (int i = 0; i < 20; i++) begin
      setIdle(); issue(16'h0500, 3'd0, 3'd0, 0, 0, 3'd2, 1, 1);
      tick();
      issue(16'h0502, 3'd2, 3'd0, 1, 0, 3'd3, 1, 0);
      tick();
      expCnt = (expCnt < 15) ? expCnt + 1 : 15;
      checkOutput($sformatf("sat%0d_cnt", i), stall_cnt, expCnt);
    end
    checkOutput("sat_final", stall_cnt, 4'hF);

    rst = 1; setIdle(); stall_in = 0;
    tick();
    checkOutput("rst2_cnt", stall_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
